pong_sound: RTL and testbench

//  Consumer end of the Pong enable/buzz path: turns single-cycle hit events into timed

---
 rtl/pong_sound_pkg.sv | 37 +++
 rtl/pong_sound_tone_divider.sv | 36 +++
 rtl/pong_sound.sv | 119 +++++++++++
 tb/tb_pong_sound.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_sound_pkg.sv
// Shared state encoding, tone identifiers and default tone constants for pong_sound.
// The goal tone is only built when PONG_GOAL_TONE_EN is defined.
package pong_sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALL = 2'd1,
    ST_PAD  = 2'd2,
    ST_GOAL = 2'd3
  } state_e;

  localparam logic [1:0] TONE_NONE = 2'd0;
  localparam logic [1:0] TONE_WALL = 2'd1;
  localparam logic [1:0] TONE_PAD  = 2'd2;
  localparam logic [1:0] TONE_GOAL = 2'd3;

  localparam int DUR_W          = 7;
  localparam int DEF_HW         = 18;
  localparam int DEF_PAD_HALF   = 32768;
  localparam int DEF_WALL_HALF  = 4096;
  localparam int DEF_GOAL_HALF  = 65536;
  localparam int DEF_GOAL_STEP  = 2048;
  localparam int DEF_PAD_TICKS  = 20;
  localparam int DEF_WALL_TICKS = 10;
  localparam int DEF_GOAL_TICKS = 100;

  // The tone id doubles as the event priority, so a new event wins when id >= current.
  function automatic logic [1:0] tone_of(state_e s);
    case (s)
      ST_WALL: return TONE_WALL;
      ST_PAD:  return TONE_PAD;
      ST_GOAL: return TONE_GOAL;
      default: return TONE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pong_sound_tone_divider.sv
// Square-wave phase generator: counts clk while run is high and flips phase every
// half clk cycles; clear returns counter and phase to zero.
module tone_divider #(
  parameter int HW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          clear,
  input  logic [HW-1:0] half,
  output logic          phase
);

  localparam logic [HW-1:0] ONE = HW'(1);

  logic [HW-1:0] cnt;

  // >= rather than == keeps the divider from running away if half ever shrinks mid-tone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (run) begin
      if (cnt >= half - ONE) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/pong_sound.sv
// Buzzer tone sequencer for Pong: hit events start timed square-wave tones.
// Define PONG_GOAL_TONE_EN to add the sweeping goal tone.
module pong_sound
  import pong_sound_pkg::*;
#(
  parameter int PAD_HALF   = DEF_PAD_HALF,
  parameter int WALL_HALF  = DEF_WALL_HALF,
  parameter int GOAL_HALF  = DEF_GOAL_HALF,
  parameter int GOAL_STEP  = DEF_GOAL_STEP,
  parameter int PAD_TICKS  = DEF_PAD_TICKS,
  parameter int WALL_TICKS = DEF_WALL_TICKS,
  parameter int GOAL_TICKS = DEF_GOAL_TICKS,
  parameter int HW         = DEF_HW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic       pause,
  input  logic       pad_hit,
  input  logic       wall_hit,
  input  logic       goal,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] tone_id
);

  state_e             state;
  logic [DUR_W-1:0]   dur;
  logic [HW-1:0]      half;
  logic [1:0]         ev_prio;
  logic               accept;
  logic               tick;
  logic               done;
  logic               run;
  logic               clear;
  logic               phase;

`ifdef PONG_GOAL_TONE_EN
  function automatic logic [HW-1:0] sat_add(logic [HW-1:0] a, logic [HW-1:0] b);
    logic [HW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[HW] ? '1 : s[HW-1:0];
  endfunction
`else
  logic unused_goal;
  assign unused_goal = goal | (GOAL_HALF == 0) | (GOAL_STEP == 0) | (GOAL_TICKS == 0);
`endif

  // Later assignments override earlier ones, giving goal > pad > wall.
  always_comb begin
    ev_prio = TONE_NONE;
    if (wall_hit) ev_prio = TONE_WALL;
    if (pad_hit)  ev_prio = TONE_PAD;
`ifdef PONG_GOAL_TONE_EN
    if (goal)     ev_prio = TONE_GOAL;
`endif
  end

  assign accept = !pause && (ev_prio != TONE_NONE) && (ev_prio >= tone_of(state));
  assign tick   = !pause && game_en && (state != ST_IDLE) && !accept;
  assign done   = tick && (dur == DUR_W'(1));
  assign run    = !pause && (state != ST_IDLE);
  assign clear  = accept || done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dur   <= '0;
      half  <= '0;
    end else if (accept) begin
      case (ev_prio)
        TONE_WALL: begin
          state <= ST_WALL;
          dur   <= DUR_W'(WALL_TICKS);
          half  <= HW'(WALL_HALF);
        end
        TONE_PAD: begin
          state <= ST_PAD;
          dur   <= DUR_W'(PAD_TICKS);
          half  <= HW'(PAD_HALF);
        end
`ifdef PONG_GOAL_TONE_EN
        TONE_GOAL: begin
          state <= ST_GOAL;
          dur   <= DUR_W'(GOAL_TICKS);
          half  <= HW'(GOAL_HALF);
        end
`endif
        default: ;
      endcase
    end else if (done) begin
      state <= ST_IDLE;
      dur   <= '0;
    end else if (tick) begin
      dur <= dur - DUR_W'(1);
`ifdef PONG_GOAL_TONE_EN
      // Goal tone falls in pitch: each counted tick lengthens the half-period.
      if (state == ST_GOAL) half <= sat_add(half, HW'(GOAL_STEP));
`endif
    end
  end

  tone_divider #(
    .HW(HW)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .half  (half),
    .phase (phase)
  );

  // Pause silences the pin without disturbing the stored phase.
  assign buzzer  = phase & ~pause;
  assign busy    = (state != ST_IDLE);
  assign tone_id = tone_of(state);

endmodule

// File: tb/tb_pong_sound.sv
// Self-checking bench for pong_sound with short tone constants and a game_en tick every 50 clk.
// Reference model tracks tone kind, ticks left and elapsed active cycles since tone entry.
module tb_pong_sound;

  localparam int PAD_HALF   = 4;
  localparam int WALL_HALF  = 2;
  localparam int GOAL_HALF  = 4;
  localparam int GOAL_STEP  = 2;
  localparam int PAD_TICKS  = 3;
  localparam int WALL_TICKS = 2;
  localparam int GOAL_TICKS = 5;
  localparam int HW         = 18;
`ifdef PONG_GOAL_TONE_EN
  localparam bit GOAL_ON = 1'b1;
`else
  localparam bit GOAL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_en;
  logic       pause;
  logic       pad_hit;
  logic       wall_hit;
  logic       goal;
  logic       buzzer;
  logic       busy;
  logic [1:0] tone_id;

  always #5 clk = ~clk;

  pong_sound #(
    .PAD_HALF  (PAD_HALF),
    .WALL_HALF (WALL_HALF),
    .GOAL_HALF (GOAL_HALF),
    .GOAL_STEP (GOAL_STEP),
    .PAD_TICKS (PAD_TICKS),
    .WALL_TICKS(WALL_TICKS),
    .GOAL_TICKS(GOAL_TICKS),
    .HW        (HW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .game_en (game_en),
    .pause   (pause),
    .pad_hit (pad_hit),
    .wall_hit(wall_hit),
    .goal    (goal),
    .buzzer  (buzzer),
    .busy    (busy),
    .tone_id (tone_id)
  );

  int checks   = 0;
  int failures = 0;
  int ge_cnt   = 0;
  bit chk_model = 1'b1;

  // Model: kind 0 none, 1 wall, 2 pad, 3 goal; act = unpaused cycles since entry.
  int m_kind  = 0;
  int m_ticks = 0;
  int m_act   = 0;

  function automatic int m_half(int k);
    return (k == 1) ? WALL_HALF : (k == 2) ? PAD_HALF : GOAL_HALF;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_ticks = 0; m_act = 0;
  endtask

  task automatic model_step();
    int prio;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (pause) return;
    prio = (GOAL_ON && goal) ? 3 : pad_hit ? 2 : wall_hit ? 1 : 0;
    if (prio != 0 && prio >= m_kind) begin
      m_kind  = prio;
      m_ticks = (prio == 1) ? WALL_TICKS : (prio == 2) ? PAD_TICKS : GOAL_TICKS;
      m_act   = 0;
    end else if (m_kind != 0) begin
      m_act++;
      if (game_en) begin
        if (m_ticks == 1) model_reset();
        else m_ticks--;
      end
    end
  endtask

  task automatic tick();
    logic exp_buz;
    model_step();
    @(posedge clk);
    #1;
    if (chk_model) begin
      exp_buz = (m_kind != 0) && !pause && (((m_act / m_half(m_kind)) % 2) == 1);
      checks += 3;
      if (buzzer !== exp_buz) begin
        failures++;
        $display("FAIL model_buzzer t=%0t got=%b want=%b", $time, buzzer, exp_buz);
      end
      if (busy !== (m_kind != 0)) begin
        failures++;
        $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, (m_kind != 0));
      end
      if (tone_id !== 2'(m_kind)) begin
        failures++;
        $display("FAIL model_tone_id t=%0t got=%0d want=%0d", $time, tone_id, m_kind);
      end
    end
    ge_cnt = (ge_cnt + 1) % 50;
  endtask

  task automatic step1();
    game_en = (ge_cnt == 49);
    tick();
    game_en = 1'b0; pad_hit = 1'b0; wall_hit = 1'b0; goal = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; game_en = 1'b0; pause = 1'b0;
    pad_hit = 1'b0; wall_hit = 1'b0; goal = 1'b0;
    #2;
    checks++;
    if ({buzzer, busy, tone_id} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {buzzer, busy, tone_id});
    end
    tick(); tick();
    rst_n = 1'b1;
    ge_cnt = 0;
    run(3);
  endtask

  task automatic test_pad();
    pad_hit = 1'b1;
    step1();
    checks++;
    if (busy !== 1'b1 || tone_id !== 2'd2) begin
      failures++;
      $display("FAIL pad_start got busy=%b id=%0d want busy=1 id=2", busy, tone_id);
    end
    run(3);
    checks++;
    if (buzzer !== 1'b0) begin
      failures++;
      $display("FAIL pad_before_toggle got=%b want=0", buzzer);
    end
    run(1);
    checks++;
    if (buzzer !== 1'b1) begin
      failures++;
      $display("FAIL pad_first_toggle got=%b want=1", buzzer);
    end
    run(160);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL pad_end got busy=%b want=0", busy);
    end
  endtask

  task automatic test_priority();
    wall_hit = 1'b1; pad_hit = 1'b1;
    step1();
    checks++;
    if (tone_id !== 2'd2) begin
      failures++;
      $display("FAIL prio_simul got=%0d want=2", tone_id);
    end
    run(3);
    wall_hit = 1'b1;
    step1();
    checks++;
    if (tone_id !== 2'd2) begin
      failures++;
      $display("FAIL prio_wall_in_pad got=%0d want=2", tone_id);
    end
    run(160);
    wall_hit = 1'b1;
    step1();
    checks++;
    if (tone_id !== 2'd1) begin
      failures++;
      $display("FAIL prio_wall_start got=%0d want=1", tone_id);
    end
    run(5);
    pad_hit = 1'b1;
    step1();
    checks++;
    if (tone_id !== 2'd2) begin
      failures++;
      $display("FAIL prio_pad_over_wall got=%0d want=2", tone_id);
    end
    run(160);
  endtask

  task automatic test_pause();
    pad_hit = 1'b1;
    step1();
    run(9);
    pause = 1'b1;
    run(30);
    checks++;
    if (buzzer !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pause_hold got buzzer=%b busy=%b want buzzer=0 busy=1", buzzer, busy);
    end
    pause = 1'b0;
    run(200);
  endtask

  task automatic test_async_reset();
    pad_hit = 1'b1;
    step1();
    run(7);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({buzzer, busy, tone_id} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got=%b want=0000", {buzzer, busy, tone_id});
    end
    model_reset();
    tick(); tick();
    #2 rst_n = 1'b1;
    pad_hit = 1'b1;
    step1();
    checks++;
    if (busy !== 1'b1 || tone_id !== 2'd2) begin
      failures++;
      $display("FAIL after_reset_start got busy=%b id=%0d want busy=1 id=2", busy, tone_id);
    end
    run(200);
  endtask

  task automatic test_coincident();
    int guard = 0;
    int busy_cnt = 0;
    while (ge_cnt != 49 && guard < 100) begin
      step1();
      guard++;
    end
    pad_hit = 1'b1;
    step1();
    if (busy) busy_cnt++;
    for (int i = 0; i < 200; i++) begin
      step1();
      if (busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== 50 * PAD_TICKS) begin
      failures++;
      $display("FAIL coincident_duration got=%0d want=%0d", busy_cnt, 50 * PAD_TICKS);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      pad_hit  = ($urandom_range(0, 39) == 0);
      wall_hit = ($urandom_range(0, 29) == 0);
      goal     = !GOAL_ON && ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 79) == 0) pause = ~pause;
      step1();
    end
    pause = 1'b0;
    run(200);
  endtask

  task automatic measure(output int n);
    logic prev;
    prev = buzzer;
    n = 0;
    do begin
      step1();
      n++;
    end while (buzzer == prev && n < 200);
  endtask

  task automatic test_goal();
`ifdef PONG_GOAL_TONE_EN
    int n;
    int guard = 0;
    chk_model = 1'b0;
    while (ge_cnt != 0 && guard < 100) begin
      step1();
      guard++;
    end
    goal = 1'b1;
    step1();
    checks++;
    if (tone_id !== 2'd3) begin
      failures++;
      $display("FAIL goal_start got=%0d want=3", tone_id);
    end
    measure(n);
    checks++;
    if (n != 4) begin failures++; $display("FAIL goal_half0 got=%0d want=4", n); end
    measure(n);
    checks++;
    if (n != 4) begin failures++; $display("FAIL goal_half0b got=%0d want=4", n); end
    for (int k = 1; k <= 2; k++) begin
      guard = 0;
      do begin
        step1();
        guard++;
      end while (ge_cnt != 0 && guard < 100);
      measure(n);
      measure(n);
      checks++;
      if (n != GOAL_HALF + k * GOAL_STEP) begin
        failures++;
        $display("FAIL goal_sweep%0d got=%0d want=%0d", k, n, GOAL_HALF + k * GOAL_STEP);
      end
    end
    pad_hit = 1'b1;
    step1();
    checks++;
    if (tone_id !== 2'd3) begin
      failures++;
      $display("FAIL goal_pad_ignored got=%0d want=3", tone_id);
    end
`else
    goal = 1'b1;
    step1();
    checks++;
    if (busy !== 1'b0 || tone_id !== 2'd0) begin
      failures++;
      $display("FAIL goal_disabled got busy=%b id=%0d want busy=0 id=0", busy, tone_id);
    end
    run(5);
`endif
  endtask

  initial begin
    test_reset();
    test_pad();
    test_priority();
    test_pause();
    test_async_reset();
    test_coincident();
    test_random();
    test_goal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
